ex_div: RTL and testbench

- Iterative RV32M divide unit inside the execute stage, fed by the ID/EX pipeline register outputs (operands, funct3, destination address, write-enable).
- Runs a 32-step restoring division. Holds the front of the pipeline through `stall_req` until the result is ready.
- Returns a one-cycle result strobe with the write-back address/enable for the EX/MEM path.

---
 rtl/ex_div.sv | 166 ++++++++++++++++
 tb/tb_ex_div.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_div.sv
// Iterative RV32M divide unit for the execute stage.
// Restoring division, one quotient bit per cycle. Holds the front of the
// pipeline while busy and emits a single-cycle write-back strobe.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a divide; latches operands on an accepted start
// CALC  | 32 restoring-division steps, stall held high
// DONE  | one-cycle result strobe, pipeline released
module ex_div #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  input  logic [4:0]        waddr_i,
  input  logic              we_i,
  input  logic              flush,
  output logic              stall_req,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic [4:0]        waddr_o,
  output logic              we_o
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [DATA_W-1:0] INT_MIN  = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] dvs_q, dvs_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              qsign_q, qsign_d;
  logic              rsign_q, rsign_d;
  logic              op_rem_q, op_rem_d;
  logic [4:0]        waddr_q, waddr_d;
  logic              we_q, we_d;

  logic              signed_op;
  logic              neg_a, neg_b;
  logic [DATA_W-1:0] abs_a, abs_b;
  logic [DATA_W:0]   rem_sh;
  logic [DATA_W+1:0] diff;
  logic [DATA_W-1:0] quo_s, rem_s;

  // funct3[2] is always set for the M-extension divides; only [1:0] select the op.
  logic unused_f3;
  assign unused_f3 = funct3[2];

  // Operand conditioning, one restoring step, and FSM next-state / outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rem_d        = rem_q;
    quo_d        = quo_q;
    dvs_d        = dvs_q;
    result_d     = result_q;
    qsign_d      = qsign_q;
    rsign_d      = rsign_q;
    op_rem_d     = op_rem_q;
    waddr_d      = waddr_q;
    we_d         = we_q;
    stall_req    = 1'b0;
    result_valid = 1'b0;

    signed_op = ~funct3[0];
    neg_a     = signed_op & dividend[DATA_W-1];
    neg_b     = signed_op & divisor[DATA_W-1];
    abs_a     = neg_a ? (~dividend + 1'b1) : dividend;
    abs_b     = neg_b ? (~divisor + 1'b1) : divisor;

    // Partial remainder needs one extra bit after the shift.
    rem_sh = {rem_q, quo_q[DATA_W-1]};
    diff   = {1'b0, rem_sh} - {2'b00, dvs_q};
    quo_s  = {quo_q[DATA_W-2:0], ~diff[DATA_W+1]};
    rem_s  = diff[DATA_W+1] ? rem_sh[DATA_W-1:0] : diff[DATA_W-1:0];

    case (state_q)
      IDLE: begin
        stall_req = start & ~flush;
        if (start && !flush) begin
          op_rem_d = funct3[1];
          waddr_d  = waddr_i;
          we_d     = we_i;
          qsign_d  = neg_a ^ neg_b;
          rsign_d  = neg_a;
          quo_d    = abs_a;
          dvs_d    = abs_b;
          rem_d    = '0;
          cnt_d    = '0;
          if (divisor == '0) begin
            result_d = funct3[1] ? dividend : '1;
            state_d  = DONE;
          end else if (signed_op && dividend == INT_MIN && divisor == '1) begin
            result_d = funct3[1] ? '0 : INT_MIN;
            state_d  = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        stall_req = 1'b1;
        if (flush) begin
          state_d = IDLE;
        end else begin
          rem_d = rem_s;
          quo_d = quo_s;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d  = DONE;
            result_d = op_rem_q ? (rsign_q ? (~rem_s + 1'b1) : rem_s)
                                : (qsign_q ? (~quo_s + 1'b1) : quo_s);
          end
        end
      end
      DONE: begin
        result_valid = ~flush;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      result_q <= '0;
      qsign_q  <= 1'b0;
      rsign_q  <= 1'b0;
      op_rem_q <= 1'b0;
      waddr_q  <= '0;
      we_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      result_q <= result_d;
      qsign_q  <= qsign_d;
      rsign_q  <= rsign_d;
      op_rem_q <= op_rem_d;
      waddr_q  <= waddr_d;
      we_q     <= we_d;
    end
  end

  assign result  = result_q;
  assign waddr_o = waddr_q;
  assign we_o    = we_q & result_valid;

endmodule

// File: tb/tb_ex_div.sv
// Scoreboard bench for ex_div: the driver pushes expected write-backs,
// a monitor pops and compares them whenever result_valid is seen.
module tb_ex_div;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'b101;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic [4:0]  waddr_i = '0;
  logic        we_i = 1'b0;
  logic        flush = 1'b0;
  logic        stall_req;
  logic [31:0] result;
  logic        result_valid;
  logic [4:0]  waddr_o;
  logic        we_o;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  wa;
    logic        we;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  ex_div #(.DATA_W(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .dividend(dividend), .divisor(divisor), .waddr_i(waddr_i), .we_i(we_i),
    .flush(flush), .stall_req(stall_req), .result(result),
    .result_valid(result_valid), .waddr_o(waddr_o), .we_o(we_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic logic [31:0] ref_div(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint x, y, q, r;
    if (b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
    if (f3[0]) begin
      x = longint'({32'd0, a});
      y = longint'({32'd0, b});
    end else begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end
    q = x / y;
    r = x % y;
    return f3[1] ? r[31:0] : q[31:0];
  endfunction

  function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Monitor: compare every result strobe against the front of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (result_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got result_valid=1 result=%h expected no strobe (t=%0t)", result, $time);
      end else begin
        e = sb.pop_front();
        check("result", result, e.res);
        check("waddr_o", 32'(waddr_o), 32'(e.wa));
        check("we_o", 32'(we_o), 32'(e.we));
        check("latency_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Drive one start for a single cycle; optionally record the expected write-back.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] wa, input logic we, input bit push);
    @(negedge clk);
    start = 1'b1; funct3 = f3; dividend = a; divisor = b; waddr_i = wa; we_i = we;
    #1 check("stall_on_start", 32'(stall_req), 32'd1);
    @(posedge clk);
    #1 start = 1'b0;
    if (push) sb.push_back('{ref_div(f3, a, b), wa, we, cyc + (is_special(f3, a, b) ? 0 : 32)});
  endtask

  task automatic wait_idle(input int bound);
    bit done = 1'b0;
    for (int i = 0; i < bound && !done; i++) begin
      @(negedge clk);
      #3;
      if (sb.size() == 0) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL timeout: %0d results outstanding, expected 0 after %0d cycles", sb.size(), bound);
      sb.delete();
    end
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a, b;
    int          sel;

    repeat (3) @(negedge clk);
    #1;
    check("rst_result", result, 32'd0);
    check("rst_valid", 32'(result_valid), 32'd0);
    check("rst_waddr", 32'(waddr_o), 32'd0);
    check("rst_we", 32'(we_o), 32'd0);
    check("rst_stall", 32'(stall_req), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // DIVU 100/7 with stall profile.
    issue(3'b101, 32'd100, 32'd7, 5'd5, 1'b1, 1'b1);
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      #1 check("stall_calc", 32'(stall_req), 32'd1);
    end
    @(negedge clk);
    #1 check("stall_done", 32'(stall_req), 32'd0);
    wait_idle(5);

    issue(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd6, 1'b1, 1'b1); wait_idle(40);
    issue(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd7, 1'b1, 1'b1); wait_idle(40);
    issue(3'b101, 32'd42, 32'd0, 5'd8, 1'b1, 1'b1);        wait_idle(5);
    issue(3'b111, 32'd42, 32'd0, 5'd9, 1'b0, 1'b1);        wait_idle(5);
    issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 1'b1, 1'b1); wait_idle(5);
    issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1'b1, 1'b1); wait_idle(5);
    issue(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1'b1, 1'b1); wait_idle(40);

    // Flush in CALC cycle 10.
    issue(3'b101, 32'd1000, 32'd3, 5'd13, 1'b1, 1'b0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    #1 check("stall_after_flush", 32'(stall_req), 32'd0);
    repeat (40) @(negedge clk);
    issue(3'b101, 32'd9, 32'd3, 5'd14, 1'b1, 1'b1); wait_idle(40);

    // Flush during DONE suppresses the strobe.
    issue(3'b101, 32'd5, 32'd0, 5'd15, 1'b1, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    #1 check("flush_done_valid", 32'(result_valid), 32'd0);
    check("flush_done_we", 32'(we_o), 32'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    issue(3'b101, 32'd8, 32'd2, 5'd16, 1'b1, 1'b1); wait_idle(40);

    // Reset in CALC cycle 20.
    issue(3'b101, 32'd1000, 32'd3, 5'd17, 1'b1, 1'b0);
    repeat (19) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_result", result, 32'd0);
    check("midrst_valid", 32'(result_valid), 32'd0);
    check("midrst_waddr", 32'(waddr_o), 32'd0);
    check("midrst_stall", 32'(stall_req), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);

    // Start while busy is ignored.
    issue(3'b101, 32'd77, 32'd5, 5'd18, 1'b1, 1'b1);
    repeat (5) @(negedge clk);
    start = 1'b1; funct3 = 3'b111; dividend = 32'd3; divisor = 32'd0; waddr_i = 5'd19;
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_idle(40);
    repeat (40) @(negedge clk);

    // Randomized back-to-back traffic.
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 7);
      f3  = 3'(4 + $urandom_range(0, 3));
      a   = $urandom;
      b   = $urandom;
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) begin a = 32'($urandom_range(0, 200)); b = 32'($urandom_range(1, 15)); end
      else if (sel == 3) b = 32'($urandom_range(1, 255)) ^ {32{b[31]}};
      issue(f3, a, b, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'b1);
      wait_idle(40);
    end

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
